// File: rtl/collision_scanner_if.sv
// Sprite/tile collision scanner bus: scan request, tile table port, results.
// The scanner attaches as slave; the requester and tile table drive master.
interface collision_scanner_if #(
    parameter int IDX_W = 4,
    parameter int X_W   = 10,
    parameter int Y_W   = 9
);
    logic             start;
    logic [X_W-1:0]   x_spr;
    logic [Y_W-1:0]   y_spr;
    logic [IDX_W-1:0] tile_addr;
    logic             tile_rd;
    logic [X_W-1:0]   tile_x;
    logic [Y_W-1:0]   tile_y;
    logic             tile_en;
    logic             busy;
    logic             done;
    logic [3:0]       is_Collision;
    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;

    modport master (
        output start, x_spr, y_spr, tile_x, tile_y, tile_en,
        input  tile_addr, tile_rd, busy, done,
        input  is_Collision, hit_any, hit_idx
    );

    modport slave (
        input  start, x_spr, y_spr, tile_x, tile_y, tile_en,
        output tile_addr, tile_rd, busy, done,
        output is_Collision, hit_any, hit_idx
    );
endinterface

// File: rtl/collision_scanner.sv
// Walks a tile table once per start and ORs per-side sprite contact flags.
// Flags: bit0 down, bit1 up, bit2 right, bit3 left; hit_idx = first hit tile.
module collision_scanner #(
    parameter int N_TILES = 16,
    parameter int IDX_W   = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int SPR_W   = 47,
    parameter int SPR_H   = 41,
    parameter int TILE_W  = 25,
    parameter int TILE_H  = 24,
    parameter int TOL     = 3
) (
    input logic                clk,
    input logic                rst,
    collision_scanner_if.slave bus
);
    localparam int XE = X_W + 2;
    localparam int YE = Y_W + 2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_TILES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t state;

    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic             rd_d;
    logic [IDX_W-1:0] addr_d;
    logic [3:0]       acc;
    logic             seen;
    logic [IDX_W-1:0] idx_acc;
    logic             clr;
    logic [3:0]       fl;

    assign clr = (state == IDLE) && bus.start;

    function automatic logic near_x(logic [XE-1:0] a, logic [XE-1:0] b);
        return (a <= b + XE'(TOL)) && (b <= a + XE'(TOL));
    endfunction

    function automatic logic near_y(logic [YE-1:0] a, logic [YE-1:0] b);
        return (a <= b + YE'(TOL)) && (b <= a + YE'(TOL));
    endfunction

    // Per-entry contact flags for the returned tile, widened so sums never wrap.
    always_comb begin
        logic [XE-1:0] xs, tx, cx, xr, txr;
        logic [YE-1:0] ys, ty, yb, tyb;
        logic          hx, vy;
        xs  = XE'(x_q);
        tx  = XE'(bus.tile_x);
        cx  = xs + XE'(SPR_W / 2);
        xr  = xs + XE'(SPR_W);
        txr = tx + XE'(TILE_W);
        ys  = YE'(y_q);
        ty  = YE'(bus.tile_y);
        yb  = ys + YE'(SPR_H);
        tyb = ty + YE'(TILE_H);
        hx  = (tx < cx) && (cx < txr);
        vy  = (ys < tyb) && (yb > ty);
        fl  = 4'b0000;
        if (rd_d && bus.tile_en) begin
            fl[0] = hx && near_y(yb, ty);
            fl[1] = hx && near_y(ys, tyb);
            fl[2] = vy && near_x(xr, tx);
            fl[3] = vy && near_x(xs, txr);
        end
    end

    // Read-return alignment and accumulation of flags across the scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d    <= 1'b0;
            addr_d  <= '0;
            acc     <= 4'b0000;
            seen    <= 1'b0;
            idx_acc <= '0;
        end else begin
            rd_d   <= bus.tile_rd;
            addr_d <= bus.tile_addr;
            if (clr) begin
                acc     <= 4'b0000;
                seen    <= 1'b0;
                idx_acc <= '0;
            end else if (|fl) begin
                acc <= acc | fl;
                if (!seen) begin
                    seen    <= 1'b1;
                    idx_acc <= addr_d;
                end
            end
        end
    end

    // Scan sequencer with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            x_q              <= '0;
            y_q              <= '0;
            bus.tile_addr    <= '0;
            bus.tile_rd      <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.is_Collision <= 4'b0000;
            bus.hit_any      <= 1'b0;
            bus.hit_idx      <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_q           <= bus.x_spr;
                        y_q           <= bus.y_spr;
                        bus.tile_addr <= '0;
                        bus.tile_rd   <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.tile_addr == LAST) begin
                        bus.tile_rd <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        bus.tile_addr <= bus.tile_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!rd_d) begin
                        bus.is_Collision <= acc;
                        bus.hit_any      <= |acc;
                        bus.hit_idx      <= idx_acc;
                        bus.done         <= 1'b1;
                        bus.busy         <= 1'b0;
                        bus.tile_addr    <= '0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
